sr_decomp_stream: RTL and testbench

//  Parametrised stream decompressor. Each DATA_W input beat carries packed IN_W-bit elements;
//  the block widens every element to OUT_W bits and emits R = OUT_W/IN_W output beats per input beat.

---
 rtl/sr_decomp_stream.sv | 121 ++++++++++++
 tb/tb_sr_decomp_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_decomp_stream.sv
// Stream decompressor: widens packed IN_W-bit elements to OUT_W bits, emitting
// R = OUT_W/IN_W output beats per input beat, framed into BURST_BEATS-beat packets.
module sr_decomp_stream #(
  parameter int DATA_W      = 64,
  parameter int IN_W        = 8,
  parameter int OUT_W       = 16,
  parameter int BURST_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              sign_mode_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic              err_o,
  input  logic              err_clr_i
);

  localparam int R       = OUT_W / IN_W;
  localparam int SLICE_W = DATA_W / R;
  localparam int N_EL    = DATA_W / OUT_W;
  localparam int SUB_W   = (R > 1) ? $clog2(R) : 1;
  localparam int OCNT_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(R - 1);
  localparam logic [OCNT_W-1:0] OCNT_LAST  = OCNT_W'(BURST_BEATS - 1);
  localparam logic [OCNT_W-1:0] OCNT_EOP_0 = OCNT_W'(BURST_BEATS - R);

  logic              r_hold_vld;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_sign;
  logic [SUB_W-1:0]  r_sub;
  logic [OCNT_W-1:0] r_ocnt;
  logic              r_err;

  logic              w_xfer;
  logic              w_last_sub;
  logic              w_accept;
  logic [OCNT_W-1:0] w_ocnt_inc;
  logic [OCNT_W-1:0] w_ocnt_next;
  logic [OCNT_W-1:0] w_first_ocnt;
  logic              w_err_set;
  logic [SLICE_W-1:0] w_slice;
  logic [IN_W-1:0]    w_elem;
  logic [OUT_W-1:0]   w_word;
  logic [DATA_W-1:0]  w_expanded;

  assign w_xfer     = r_hold_vld && ready_i;
  assign w_last_sub = (r_sub == SUB_LAST);
  assign ready_o    = !r_hold_vld || (ready_i && w_last_sub);
  assign w_accept   = valid_i && ready_o;

  // Checks compare against the ocnt this beat's first output would carry.
  assign w_ocnt_inc   = (r_ocnt == OCNT_LAST) ? '0 : r_ocnt + 1'b1;
  assign w_ocnt_next  = w_xfer ? w_ocnt_inc : r_ocnt;
  assign w_first_ocnt = sop_i ? '0 : w_ocnt_next;
  assign w_err_set    = w_accept && (( sop_i && (w_ocnt_next != '0)) ||
                                     (!sop_i && (w_ocnt_next == '0)) ||
                                     ( eop_i && (w_first_ocnt != OCNT_EOP_0)));

  assign w_slice = r_hold_data[DATA_W-1 - int'(r_sub)*SLICE_W -: SLICE_W];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_expanded = '0;
    w_elem     = '0;
    w_word     = '0;
    for (int k = 0; k < N_EL; k++) begin
      w_elem          = w_slice[SLICE_W-1 - k*IN_W -: IN_W];
      w_word          = {OUT_W{r_hold_sign & w_elem[IN_W-1]}};
      w_word[IN_W-1:0] = w_elem;
      w_expanded[DATA_W-1 - k*OUT_W -: OUT_W] = w_word;
    end
  end

  assign valid_o = r_hold_vld;
  assign data_o  = r_hold_vld ? w_expanded : '0;
  assign sop_o   = r_hold_vld && (r_ocnt == '0);
  assign eop_o   = r_hold_vld && (r_ocnt == OCNT_LAST);
  assign err_o   = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_sign <= 1'b0;
      r_sub       <= '0;
      r_ocnt      <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= data_i;
        r_hold_sign <= sign_mode_i;
        r_sub       <= '0;
      end else if (w_xfer) begin
        if (w_last_sub) begin
          r_hold_vld <= 1'b0;
          r_sub      <= '0;
        end else begin
          r_sub <= r_sub + 1'b1;
        end
      end

      if (w_accept && sop_i) r_ocnt <= '0;
      else if (w_xfer)       r_ocnt <= w_ocnt_inc;

      if (w_err_set)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_decomp_stream.sv
// Self-checking bench for sr_decomp_stream: table vectors, framing/backpressure/reset
// sequences, and a randomized stream compared against a queue-based reference model.
module tb_sr_decomp_stream;

  localparam int DATA_W = 64;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 16;
  localparam int BB     = 16;
  localparam int R      = OUT_W / IN_W;
  localparam int N_EL   = DATA_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic              sop_i = 1'b0;
  logic              eop_i = 1'b0;
  logic              sign_mode_i = 1'b0;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              sop_o;
  logic              eop_o;
  logic              ready_i = 1'b1;
  logic              err_o;
  logic              err_clr_i = 1'b0;

  sr_decomp_stream #(.DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W), .BURST_BEATS(BB)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .sop_i(sop_i),
    .eop_i(eop_i), .sign_mode_i(sign_mode_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .ready_i(ready_i), .err_o(err_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending output words, packet position, sticky error.
  logic [DATA_W-1:0] q[$];
  int  m_ocnt = 0;
  bit  m_err = 1'b0;
  bit  m_accepted = 1'b0;
  int  cyc = 0;
  int  n_val, n_sop, n_eop, first_val, last_val;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] expand(input logic [DATA_W-1:0] d, input int s, input bit sign);
    logic [DATA_W-1:0] res;
    longint unsigned v;
    int shift;
    res = '0;
    for (int k = 0; k < N_EL; k++) begin
      shift = DATA_W - (s*N_EL + k + 1) * IN_W;
      v = (d >> shift) & ((64'd1 << IN_W) - 1);
      if (sign && v >= (64'd1 << (IN_W-1))) v = v + ((64'd1 << OUT_W) - (64'd1 << IN_W));
      res = res | (64'(v) << (DATA_W - (k + 1) * OUT_W));
    end
    return res;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ocnt = 0;
    m_err  = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    bit exp_valid, exp_ready, err_set;
    int first;
    @(negedge clk);
    exp_valid = (q.size() > 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && ready_i);
    check("valid_o", 64'(valid_o), 64'(exp_valid));
    check("ready_o", 64'(ready_o), 64'(exp_ready));
    check("err_o", 64'(err_o), 64'(m_err));
    if (exp_valid) begin
      check("data_o", data_o, q[0]);
      check("sop_o", 64'(sop_o), 64'(m_ocnt == 0));
      check("eop_o", 64'(eop_o), 64'(m_ocnt == BB-1));
    end
    if (valid_o) begin
      n_val++;
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
    end
    if (sop_o) n_sop++;
    if (eop_o) n_eop++;

    m_accepted = valid_i && exp_ready;
    err_set = 1'b0;
    if (exp_valid && ready_i) begin
      void'(q.pop_front());
      m_ocnt = (m_ocnt + 1) % BB;
    end
    if (m_accepted) begin
      first = m_ocnt;
      if (sop_i && first != 0)  err_set = 1'b1;
      if (!sop_i && first == 0) err_set = 1'b1;
      if (sop_i) first = 0;
      if (eop_i && (first + R - 1) != BB - 1) err_set = 1'b1;
      m_ocnt = first;
      for (int s = 0; s < R; s++) q.push_back(expand(data_i, s, sign_mode_i));
    end
    if (err_set) m_err = 1'b1;
    else if (err_clr_i) m_err = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic s, input logic e, input logic sg);
    valid_i = 1'b1; data_i = d; sop_i = s; eop_i = e; sign_mode_i = sg;
    for (int n = 0; n < 64; n++) begin
      step();
      if (m_accepted) return;
    end
    checks++; errors++;
    $display("FAIL send_timeout: beat %h not accepted within 64 clks", d);
  endtask

  task automatic drain();
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    for (int n = 0; n < 64 && q.size() > 0; n++) step();
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats still pending", q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
    check({tag, "_data_o"},  data_o,       64'd0);
    check({tag, "_sop_o"},   64'(sop_o),   64'd0);
    check({tag, "_eop_o"},   64'(eop_o),   64'd0);
    check({tag, "_ready_o"}, 64'(ready_o), 64'd1);
    check({tag, "_err_o"},   64'(err_o),   64'd0);
  endtask

  task automatic do_reset();
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; err_clr_i = 1'b0; ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_stats();
    n_val = 0; n_sop = 0; n_eop = 0; first_val = -1; last_val = -1;
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sign;
    logic [DATA_W-1:0] exp0;
    logic [DATA_W-1:0] exp1;
  } vec_t;

  vec_t vecs[6];

  logic [DATA_W-1:0] held_data;
  logic              held_sop, held_eop;

  initial begin
    vecs[0] = '{64'h807F_01FF_0010_F022, 1'b1, 64'hFF80_007F_0001_FFFF, 64'h0000_0010_FFF0_0022};
    vecs[1] = '{64'h807F_01FF_0010_F022, 1'b0, 64'h0080_007F_0001_00FF, 64'h0000_0010_00F0_0022};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h00FF_00FF_00FF_00FF, 64'h00FF_00FF_00FF_00FF};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b1, 64'h0001_0023_0045_0067, 64'hFF89_FFAB_FFCD_FFEF};
    vecs[5] = '{64'h0123_4567_89AB_CDEF, 1'b0, 64'h0001_0023_0045_0067, 64'h0089_00AB_00CD_00EF};
    clear_stats();

    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_beat(vecs[i].data, 1'b1, 1'b0, vecs[i].sign);
      valid_i = 1'b0;
      check($sformatf("vec%0d_beat0", i), data_o, vecs[i].exp0);
      step();
      check($sformatf("vec%0d_beat1", i), data_o, vecs[i].exp1);
      step();
    end
    drain();

    // Full packet, back to back, no bubbles.
    do_reset();
    clear_stats();
    for (int i = 0; i < 8; i++) send_beat({$urandom, $urandom}, i == 0, i == 7, 1'b1);
    drain();
    check("pkt_valid_beats", 64'(n_val), 64'd16);
    check("pkt_span", 64'(last_val - first_val + 1), 64'd16);
    check("pkt_sop_count", 64'(n_sop), 64'd1);
    check("pkt_eop_count", 64'(n_eop), 64'd1);
    check("pkt_err", 64'(err_o), 64'd0);

    // Backpressure on output beat 1.
    do_reset();
    send_beat(64'hA1B2_C3D4_E5F6_0718, 1'b1, 1'b0, 1'b0);
    valid_i = 1'b1; data_i = 64'h1122_3344_5566_7788; sop_i = 1'b0;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    held_data = data_o; held_sop = sop_o; held_eop = eop_o;
    for (int n = 0; n < 3; n++) begin
      step();
      check("bp_data_stable", data_o, held_data);
      check("bp_sop_stable", 64'(sop_o), 64'(held_sop));
      check("bp_eop_stable", 64'(eop_o), 64'(held_eop));
      check("bp_ready_low", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    send_beat(64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) send_beat({$urandom, $urandom}, 1'b0, i == 7, i[0]);
    drain();
    check("bp_err", 64'(err_o), 64'd0);

    // Unexpected sop on input beat #3: error and realignment.
    do_reset();
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, i == 0, 1'b0, 1'b1);
    send_beat(64'h0F0F_F0F0_1234_8765, 1'b1, 1'b0, 1'b1);
    check("frm_err_set", 64'(err_o), 64'd1);
    check("frm_realign_sop", 64'(sop_o), 64'd1);
    drain();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("frm_err_cleared", 64'(err_o), 64'd0);

    // Asynchronous reset while output beat 5 is presented.
    do_reset();
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, i == 0, 1'b0, 1'b0);
    valid_i = 1'b0;
    step();
    check("pre_rst_valid", 64'(valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(64'h7766_5544_3322_1100, 1'b1, 1'b0, 1'b1);
    check("post_rst_sop", 64'(sop_o), 64'd1);
    drain();

    // Randomized stream against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      valid_i     = ($urandom_range(0, 3) != 0);
      data_i      = {$urandom, $urandom};
      sop_i       = ($urandom_range(0, 7) == 0);
      eop_i       = ($urandom_range(0, 7) == 0);
      sign_mode_i = $urandom_range(0, 1) == 1;
      ready_i     = ($urandom_range(0, 3) != 0);
      err_clr_i   = ($urandom_range(0, 15) == 0);
      step();
    end
    err_clr_i = 1'b0;
    ready_i   = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
